adder3_stream_reducer: RTL and testbench

- Sequencer that feeds a shared 3-operand adder (accumulator + two 8-bit operands) to reduce a burst of 8-bit words to one sum.
- Accepts words on a valid/ready stream terminated by in_last.
- Pairs words so each add cycle consumes two inputs, then presents the total, word count and an overflow flag on a valid/ready result port.
- Sits between an operand source and a result consumer in the monad-examples arithmetic designs.

---
 rtl/adder3_stream_reducer.sv | 114 +++++++++++
 tb/tb_adder3_stream_reducer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/adder3_stream_reducer.sv
// rtl/adder3_stream_reducer.sv - reduces a burst of 8-bit words to one sum via a shared 3-operand adder
module adder3_stream_reducer #(
    parameter int SUM_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_overflow
);

    typedef enum logic [1:0] {WAIT_A, WAIT_B, OUTPUT} state_t;

    state_t               state, state_next;
    logic [SUM_WIDTH-1:0] acc, acc_next;
    logic [7:0]           hold, hold_next;
    logic [CNT_WIDTH-1:0] count, count_next, count_inc;
    logic                 ovf, ovf_next;
    logic [7:0]           op_a, op_b;
    logic                 do_add;
    logic [SUM_WIDTH+1:0] sum_wide;
    logic                 accept, take;

    assign in_ready     = (state != OUTPUT);
    assign out_valid    = (state == OUTPUT);
    assign out_sum      = acc;
    assign out_count    = count;
    assign out_overflow = ovf;

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    assign count_inc = (count == {CNT_WIDTH{1'b1}}) ? count
                     : count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Two guard bits catch the carry of the 3-operand add.
    assign sum_wide = {2'b00, acc}
                    + {{(SUM_WIDTH-6){1'b0}}, op_a}
                    + {{(SUM_WIDTH-6){1'b0}}, op_b};

    always_comb begin
        state_next = state;
        acc_next   = acc;
        hold_next  = hold;
        count_next = count;
        ovf_next   = ovf;
        op_a       = 8'd0;
        op_b       = 8'd0;
        do_add     = 1'b0;
        case (state)
            WAIT_A: begin
                if (accept) begin
                    count_next = count_inc;
                    if (in_last) begin
                        // Odd-length tail: add the lone word with a zero partner.
                        op_a       = in_data;
                        do_add     = 1'b1;
                        state_next = OUTPUT;
                    end else begin
                        hold_next  = in_data;
                        state_next = WAIT_B;
                    end
                end
            end
            WAIT_B: begin
                if (accept) begin
                    count_next = count_inc;
                    op_a       = hold;
                    op_b       = in_data;
                    do_add     = 1'b1;
                    state_next = in_last ? OUTPUT : WAIT_A;
                end
            end
            OUTPUT: begin
                if (take) begin
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    state_next = WAIT_A;
                end
            end
            default: state_next = WAIT_A;
        endcase
        if (do_add) begin
            acc_next = sum_wide[SUM_WIDTH-1:0];
            if (|sum_wide[SUM_WIDTH+1:SUM_WIDTH])
                ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_A;
            acc   <= '0;
            hold  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            hold  <= hold_next;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_adder3_stream_reducer.sv
// tb/tb_adder3_stream_reducer.sv - directed and randomized bench for adder3_stream_reducer
module tb_adder3_stream_reducer;

    localparam int SW = 9;
    localparam int CW = 4;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [7:0]    in_data;
    logic          out_valid, out_ready, out_overflow;
    logic [SW-1:0] out_sum;
    logic [CW-1:0] out_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    adder3_stream_reducer #(.SUM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < TMO) begin
            tick();
            n++;
        end
        if (n >= TMO) chk("send_timeout_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input int exp_sum, input int exp_cnt, input int exp_ovf);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < TMO) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, exp_sum);
        chk({tag, "_count"}, out_count, exp_cnt);
        chk({tag, "_ovf"}, out_overflow, exp_ovf);
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int words[$];
        int total, len, cmax;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_sum", out_sum, 0);
        chk("reset_count", out_count, 0);
        chk("reset_ovf", out_overflow, 0);

        // Odd burst, result must be visible the cycle after the last accept, for one cycle.
        out_ready = 1'b1;
        send(8'd4, 1'b0); send(8'd5, 1'b0); send(8'd11, 1'b1);
        chk("odd_valid_latency", out_valid, 1);
        chk("odd_sum", out_sum, 20);
        chk("odd_count", out_count, 3);
        chk("odd_ovf", out_overflow, 0);
        tick();
        chk("odd_valid_one_cycle", out_valid, 0);
        out_ready = 1'b0;

        // Even burst with two idle cycles between words.
        send(8'd15, 1'b0);
        repeat (2) begin chk("gap_in_ready", in_ready, 1); tick(); end
        send(8'd3, 1'b0);
        repeat (2) begin chk("gap_in_ready", in_ready, 1); tick(); end
        send(8'd200, 1'b0);
        repeat (2) begin chk("gap_in_ready", in_ready, 1); tick(); end
        send(8'd1, 1'b1);
        get_result("even", 219, 4, 0);

        send(8'd255, 1'b1);
        get_result("single255", 255, 1, 0);
        send(8'd7, 1'b1);
        get_result("single7", 7, 1, 0);

        send(8'd255, 1'b0); send(8'd255, 1'b0); send(8'd3, 1'b1);
        get_result("ovf", 1, 3, 1);
        send(8'd2, 1'b1);
        get_result("ovf_clear", 2, 1, 0);

        // Backpressure with a word waiting at the input.
        send(8'd4, 1'b0); send(8'd5, 1'b0); send(8'd11, 1'b1);
        in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
        repeat (5) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 20);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        chk("bp_handshake_valid", out_valid, 0);
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_not_accepted_count", out_count, 0);

        // Reset mid-burst with a word offered in the reset cycle.
        send(8'd4, 1'b0); send(8'd5, 1'b0);
        in_valid = 1'b1; in_data = 8'd9; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_mid_sum", out_sum, 0);
        chk("rst_mid_count", out_count, 0);
        chk("rst_mid_ovf", out_overflow, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        send(8'd7, 1'b1);
        get_result("rst_after", 7, 1, 0);

        // Random bursts against an arithmetic reference: total, wrap, saturating count.
        cmax = (1 << CW) - 1;
        for (int b = 0; b < 25; b++) begin
            words.delete();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) words.push_back($urandom_range(0, 255));
            total = 0;
            foreach (words[i]) total += words[i];
            for (int i = 0; i < len; i++) begin
                send(8'(words[i]), (i == len - 1));
                if ($urandom_range(0, 3) == 0 && i != len - 1) repeat ($urandom_range(1, 3)) tick();
            end
            repeat ($urandom_range(0, 3)) tick();
            get_result("rand", total % (1 << SW), (len > cmax) ? cmax : len,
                       (total >= (1 << SW)) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
